set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15: word address width.
REQ-002 SHALL have parameter WORD_SIZE, default 32: data word width in bits.
REQ-003 SHALL have parameter WORD_COUNT, default 4: words per block, power of 2; OFFSET = log2(WORD_COUNT).
REQ-004 SHALL have parameter SETS, default 512: sets, power of 2; INDEX = log2(SETS); TAG = ADDR_WIDTH-INDEX-OFFSET.
REQ-005 SHALL have parameter WAYS, default 2: associativity; legal values 1, 2, 4.
REQ-006 SHALL have parameter CNT_WIDTH, default 14: statistics counter width.
REQ-007 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port req_valid, input, 1: read request present.
REQ-010 SHALL have port req_ready, output, 1: request can be accepted.
REQ-011 SHALL have port req_addr, input, ADDR_WIDTH: word address {tag, index, offset}.
REQ-012 SHALL have port flush, input, 1: invalidate-all request.
REQ-013 SHALL have port resp_valid, output, 1: response data valid.
REQ-014 SHALL have port resp_ready, input, 1: consumer takes the response.
REQ-015 SHALL have port resp_data, output, WORD_SIZE: the addressed word.
REQ-016 SHALL have port resp_hit, output, 1: the response was a hit.
REQ-017 SHALL have port mem_req, output, 1: block fetch request to main memory.
REQ-018 SHALL have port mem_addr, output, ADDR_WIDTH: block-aligned address, offset bits zero.
REQ-019 SHALL have port mem_ready, input, 1: mem_block is valid this cycle.
REQ-020 SHALL have port mem_block, input, WORD_COUNT*WORD_SIZE: the block; word i is at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-021 SHALL have port hit_count, output, CNT_WIDTH: number of hits.
REQ-022 SHALL have port access_count, output, CNT_WIDTH: number of lookups.

Function
REQ-023 SHALL implement the FSM states IDLE, LOOKUP, MISS, FILL and RESP; req_ready SHALL be 1 only in IDLE with flush low.
REQ-024 In IDLE, flush high SHALL clear every valid bit and every victim pointer in one cycle, SHALL take priority over req_valid, and SHALL leave the counters unchanged.
REQ-025 A request accepted at edge T (IDLE, req_valid=1, flush=0) SHALL register req_addr and move to LOOKUP.
REQ-026 LOOKUP: a hit means any way in the indexed set is valid with a matching tag (at most one way can match); hit -> RESP with resp_hit=1; miss -> MISS.
REQ-027 LOOKUP SHALL increment access_count, and on a hit also hit_count; both SHALL saturate at all-ones.
REQ-028 Hit latency SHALL be resp_valid high 2 cycles after acceptance.
REQ-029 MISS SHALL hold mem_req=1 and a stable mem_addr until a cycle with mem_ready=1; mem_block SHALL be captured in that cycle, then the FSM SHALL go to FILL.
REQ-030 mem_ready SHALL be ignored while mem_req=0.
REQ-031 Victim way selection: the lowest-index invalid way; if all ways are valid, the set's round-robin pointer, which then increments modulo WAYS.
REQ-032 FILL SHALL write the block, tag and valid bit into the victim way, then go to RESP with resp_hit=0 and resp_data taken from the filled block.
REQ-033 RESP SHALL hold resp_valid, resp_data and resp_hit stable until resp_ready=1, then return to IDLE; a new request SHALL be accepted no earlier than the next cycle.
REQ-034 WAYS=1 SHALL behave as a direct-mapped cache; the victim is always way 0.

Reset
REQ-035 rst=0 SHALL immediately, without waiting for clk, force IDLE, clear all valid bits and victim pointers, and zero both counters.
REQ-036 rst=0 SHALL also drive req_ready=0, resp_valid=0, resp_hit=0, resp_data=0, mem_req=0 and mem_addr=0.
REQ-037 Reset mid-miss SHALL drop the request; a mem_ready arriving after reset SHALL be ignored.
REQ-038 Data arrays need no reset.

Verification
REQ-039 Cold read of 0x0005 with mem_ready 3 cycles after mem_req -> mem_addr=0x0004; resp_data = word 1 of the block; resp_hit=0; access_count=1, hit_count=0.
REQ-040 Repeat read of 0x0006 -> resp_valid 2 cycles after acceptance; resp_hit=1; hit_count=1; mem_req stays 0.
REQ-041 WAYS=2: reads of 0x0000, 0x0800, 0x1000 (same set, three tags) -> the third read evicts way 0; a following read of 0x0800 hits and 0x0000 misses.
REQ-042 flush in IDLE, then re-read 0x0005 -> miss; counters unchanged by the flush.
REQ-043 rst pulsed low during MISS -> mem_req falls without a clock edge; a later mem_ready produces no response; counters read 0.
REQ-044 Hold resp_ready=0 for 5 cycles with req_valid=1 -> response stable, req_ready=0 throughout; drive hit_count to all-ones (0x3FFF) -> it stays at 0x3FFF on further hits.

Source files
------------

// File: rtl/set_assoc_cache_if.sv
// Request/response, memory-fill and statistics bundle for set_assoc_cache.
// The slave modport is the cache's view; master is the requester/memory side.
interface set_assoc_cache_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int WORD_SIZE  = 32,
    parameter int WORD_COUNT = 4,
    parameter int CNT_WIDTH  = 14
) ();
    logic                            req_valid;
    logic                            req_ready;
    logic [ADDR_WIDTH-1:0]           req_addr;
    logic                            flush;
    logic                            resp_valid;
    logic                            resp_ready;
    logic [WORD_SIZE-1:0]            resp_data;
    logic                            resp_hit;
    logic                            mem_req;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic                            mem_ready;
    logic [WORD_COUNT*WORD_SIZE-1:0] mem_block;
    logic [CNT_WIDTH-1:0]            hit_count;
    logic [CNT_WIDTH-1:0]            access_count;

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        input  mem_ready, mem_block,
        output req_ready, resp_valid, resp_data, resp_hit,
        output mem_req, mem_addr, hit_count, access_count
    );

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        output mem_ready, mem_block,
        input  req_ready, resp_valid, resp_data, resp_hit,
        input  mem_req, mem_addr, hit_count, access_count
    );
endinterface

// File: rtl/set_assoc_cache.sv
// Blocking read-only set-associative cache with round-robin replacement,
// whole-block refill from main memory and saturating hit/access counters.
module set_assoc_cache #(
    parameter int ADDR_WIDTH = 15,
    parameter int WORD_SIZE  = 32,
    parameter int WORD_COUNT = 4,
    parameter int SETS       = 512,
    parameter int WAYS       = 2,
    parameter int CNT_WIDTH  = 14
) (
    input logic              clk,
    input logic              rst,
    set_assoc_cache_if.slave bus
);
    localparam int OFFSET = $clog2(WORD_COUNT);
    localparam int INDEX  = $clog2(SETS);
    localparam int TAG    = ADDR_WIDTH - INDEX - OFFSET;
    localparam int WB     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK    = WORD_COUNT * WORD_SIZE;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] MISS   = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BLK-1:0]        blk_q;
    logic [WB-1:0]         way_q;
    logic [WORD_SIZE-1:0]  rdata_q;
    logic                  rhit_q;
    logic [CNT_WIDTH-1:0]  hcnt_q;
    logic [CNT_WIDTH-1:0]  acnt_q;

    logic [WAYS-1:0]       valid_q  [SETS];
    logic [WB-1:0]         rr_q     [SETS];
    logic [TAG-1:0]        tag_mem  [SETS][WAYS];
    logic [BLK-1:0]        data_mem [SETS][WAYS];

    logic [TAG-1:0]        tag_w;
    logic [INDEX-1:0]      idx_w;
    logic [OFFSET-1:0]     off_w;
    logic                  hit;
    logic [WB-1:0]         hit_way;
    logic [WB-1:0]         victim;
    logic                  all_valid;
    logic [WB-1:0]         rr_cur;
    logic [WB-1:0]         rr_next;
    logic [WORD_SIZE-1:0]  hit_word;
    logic [WORD_SIZE-1:0]  fill_word;
    logic                  acc_full;
    logic                  hit_full;

    assign tag_w = addr_q[ADDR_WIDTH-1 -: TAG];
    assign idx_w = addr_q[OFFSET +: INDEX];
    assign off_w = addr_q[OFFSET-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_w][w] && tag_mem[idx_w][w] == tag_w) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    // Lowest invalid way wins; a full set falls back to its rr pointer.
    always_comb begin
        rr_cur    = rr_q[idx_w];
        all_valid = &valid_q[idx_w];
        victim    = rr_cur;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_w][w]) begin
                victim = WB'(w);
            end
        end
    end

    assign rr_next   = (rr_cur == WB'(WAYS - 1)) ? '0 : rr_cur + 1'b1;
    assign hit_word  = data_mem[idx_w][hit_way][int'(off_w) * WORD_SIZE +: WORD_SIZE];
    assign fill_word = blk_q[int'(off_w) * WORD_SIZE +: WORD_SIZE];
    assign acc_full  = &acnt_q;
    assign hit_full  = &hcnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.flush && bus.req_valid) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = hit ? RESP : MISS;
            MISS: begin
                if (bus.mem_ready) begin
                    state_d = FILL;
                end
            end
            FILL: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            way_q   <= '0;
            rdata_q <= '0;
            rhit_q  <= 1'b0;
            hcnt_q  <= '0;
            acnt_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            rr_q[s]    <= '0;
                        end
                    end else if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                    end
                end
                LOOKUP: begin
                    if (!acc_full) begin
                        acnt_q <= acnt_q + 1'b1;
                    end
                    rhit_q <= hit;
                    if (hit) begin
                        rdata_q <= hit_word;
                        way_q   <= hit_way;
                        if (!hit_full) begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                end
                MISS: begin
                    if (bus.mem_ready) begin
                        way_q <= victim;
                        if (all_valid) begin
                            rr_q[idx_w] <= rr_next;
                        end
                    end
                end
                FILL: begin
                    valid_q[idx_w][way_q] <= 1'b1;
                    rdata_q <= fill_word;
                    rhit_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Data/tag storage carries no reset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (state_q == MISS && bus.mem_ready) begin
            blk_q <= bus.mem_block;
        end
        if (state_q == FILL) begin
            tag_mem[idx_w][way_q]  <= tag_w;
            data_mem[idx_w][way_q] <= blk_q;
        end
    end

    assign bus.req_ready    = rst && (state_q == IDLE) && !bus.flush;
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_data    = rdata_q;
    assign bus.resp_hit     = rhit_q;
    assign bus.mem_req      = (state_q == MISS);
    assign bus.mem_addr     = bus.mem_req
                            ? {addr_q[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}}
                            : '0;
    assign bus.hit_count    = hcnt_q;
    assign bus.access_count = acnt_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: vector table of reads plus
// flush, mid-miss reset, response stall and counter saturation sequences.
module tb_set_assoc_cache;
    localparam int AW = 15;
    localparam int WS = 32;
    localparam int WC = 4;
    localparam int CW = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    set_assoc_cache_if #(
        .ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORD_COUNT(WC), .CNT_WIDTH(CW)
    ) bus ();

    set_assoc_cache #(
        .ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORD_COUNT(WC),
        .SETS(512), .WAYS(2), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic [14:0] blk, input int i);
        return 32'hA500_0000 | (32'(blk) << 4) | 32'(i);
    endfunction

    // Memory model: answers every fetch 3 cycles after mem_req rises.
    bit          mem_auto  = 1'b1;
    bit          mem_force = 1'b0;
    bit          saw_mem   = 1'b0;
    logic [14:0] maddr     = '0;
    int          mem_wait  = 0;

    always @(negedge clk) begin
        if (!mem_auto) begin
            bus.mem_ready = mem_force;
            bus.mem_block = {WC{32'hDEAD_BEEF}};
            mem_wait = 0;
        end else if (bus.mem_req) begin
            saw_mem = 1'b1;
            maddr   = bus.mem_addr;
            if (mem_wait == 3) begin
                bus.mem_ready = 1'b1;
                for (int i = 0; i < WC; i++)
                    bus.mem_block[i*WS +: WS] = mkw(bus.mem_addr, i);
                mem_wait = 0;
            end else begin
                bus.mem_ready = 1'b0;
                mem_wait++;
            end
        end else begin
            bus.mem_ready = 1'b0;
            mem_wait = 0;
        end
    end

    task automatic do_read(input logic [14:0] a, output logic [31:0] d,
                           output logic h, output int lat);
        int n;
        saw_mem = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
            lat++;
        end
        if (!bus.resp_valid) chk("resp_timeout", 64'd0, 64'd1);
        d = bus.resp_data;
        h = bus.resp_hit;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [14:0] addr;
        logic        hit;
        logic [31:0] data;
        logic        mem;
        logic [14:0] maddr;
        int          acc;
        int          hc;
    } vec_t;

    vec_t        v[8];
    logic [31:0] d, d0;
    logic        h;
    int          lat, n, seen;

    initial begin
        v[0] = '{15'h0005, 1'b0, mkw(15'h0004, 1), 1'b1, 15'h0004, 1, 0};
        v[1] = '{15'h0006, 1'b1, mkw(15'h0004, 2), 1'b0, 15'h0000, 2, 1};
        v[2] = '{15'h0000, 1'b0, mkw(15'h0000, 0), 1'b1, 15'h0000, 3, 1};
        v[3] = '{15'h0800, 1'b0, mkw(15'h0800, 0), 1'b1, 15'h0800, 4, 1};
        v[4] = '{15'h1000, 1'b0, mkw(15'h1000, 0), 1'b1, 15'h1000, 5, 1};
        v[5] = '{15'h0801, 1'b1, mkw(15'h0800, 1), 1'b0, 15'h0000, 6, 2};
        v[6] = '{15'h0002, 1'b0, mkw(15'h0000, 2), 1'b1, 15'h0000, 7, 2};
        v[7] = '{15'h1003, 1'b1, mkw(15'h1000, 3), 1'b0, 15'h0000, 8, 3};

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_acc", bus.access_count, 0);
        chk("rst_hits", bus.hit_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", bus.req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            do_read(v[i].addr, d, h, lat);
            chk($sformatf("v%0d_hit", i), h, v[i].hit);
            chk($sformatf("v%0d_data", i), d, v[i].data);
            chk($sformatf("v%0d_memreq", i), saw_mem, v[i].mem);
            if (v[i].mem) chk($sformatf("v%0d_maddr", i), maddr, v[i].maddr);
            if (v[i].hit) chk($sformatf("v%0d_lat", i), lat, 2);
            chk($sformatf("v%0d_acc", i), bus.access_count, v[i].acc);
            chk($sformatf("v%0d_hits", i), bus.hit_count, v[i].hc);
        end

        // Flush with a simultaneous request: flush wins, counters hold.
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h1003;
        #1 chk("flush_req_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_idle", bus.req_ready, 1);
        chk("flush_acc", bus.access_count, 8);
        chk("flush_hits", bus.hit_count, 3);
        do_read(15'h0005, d, h, lat);
        chk("postflush_hit", h, 0);
        chk("postflush_data", d, mkw(15'h0004, 1));
        chk("postflush_mem", saw_mem, 1);
        do_read(15'h1003, d, h, lat);
        chk("postflush2_hit", h, 0);
        chk("postflush_acc", bus.access_count, 10);
        chk("postflush_hits", bus.hit_count, 3);

        // Reset in the middle of a miss.
        mem_auto = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h0100;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mr_mem_req_up", bus.mem_req, 1);
        chk("mr_mem_addr", bus.mem_addr, 15'h0100);
        #2 rst = 1'b0;
        #1;
        chk("mr_mem_req_drop", bus.mem_req, 0);
        chk("mr_mem_addr0", bus.mem_addr, 0);
        chk("mr_req_ready", bus.req_ready, 0);
        chk("mr_resp_valid", bus.resp_valid, 0);
        chk("mr_resp_hit", bus.resp_hit, 0);
        chk("mr_acc", bus.access_count, 0);
        chk("mr_hits", bus.hit_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 mem_force = 1'b1;
        @(posedge clk);
        #1 mem_force = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_req) seen++;
        end
        chk("mr_late_ready_ignored", seen, 0);
        chk("mr_idle", bus.req_ready, 1);
        mem_auto = 1'b1;

        do_read(15'h0005, d, h, lat);
        chk("rr_miss_after_rst", h, 0);
        chk("rr_acc", bus.access_count, 1);

        // Response stall with a pending request.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h0006;
        @(posedge clk);
        #1 bus.req_addr = 15'h0100;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        d0 = bus.resp_data;
        chk("stall_first_data", d0, mkw(15'h0004, 2));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", c), bus.resp_valid, 1);
            chk($sformatf("stall%0d_data", c), bus.resp_data, d0);
            chk($sformatf("stall%0d_hit", c), bus.resp_hit, 1);
            chk($sformatf("stall%0d_rdy", c), bus.req_ready, 0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("stall_acc", bus.access_count, 2);
        chk("stall_hits", bus.hit_count, 1);

        // Drive both counters to saturation with repeated hits.
        for (int i = 0; i < 16382; i++) do_read(15'h0006, d, h, lat);
        chk("sat_hits", bus.hit_count, 14'h3FFF);
        chk("sat_acc", bus.access_count, 14'h3FFF);
        do_read(15'h0007, d, h, lat);
        chk("sat_extra_hit", h, 1);
        chk("sat_extra_data", d, mkw(15'h0004, 3));
        chk("sat_hits_hold", bus.hit_count, 14'h3FFF);
        chk("sat_acc_hold", bus.access_count, 14'h3FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
